// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus: pipeline hazard inputs and the stall/flush/bubble controls.
// The master drives the pipeline-side inputs; the sequencer attaches as slave.
`default_nettype none

interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             ex_mdu_start;
  logic             mdu_done;
  logic             mem_req;
  logic             mem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             bubble_ex;
  logic             bubble_mem;
  logic [1:0]       seq_state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read, ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
           bubble_mem, seq_state, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read, ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
           bubble_mem, seq_state, mem_timeout, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_sequencer.sv
// ===========================================================================
// Module   : hazard_sequencer
// Function : Pipeline hazard sequencer - load-use, redirect, MDU and memory
//            wait stalls, plus memory-timeout flag and stall-cycle counter.
// Revision : 1.0 - initial release
// ===========================================================================
`default_nettype none

module hazard_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  wire               clk,
  input  wire               rst_n,
  hazard_sequencer_if.slave bus
);

  localparam int c_wait_w = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_timeout    = c_wait_w'(MEM_TIMEOUT);
  localparam logic [c_wait_w-1:0] c_timeout_m1 = c_wait_w'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MDU_BUSY  = 2'd1,
    ST_MDU_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic w_mem_hold;
  logic w_load_use;
  logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic w_flush_id, w_bubble_ex, w_bubble_mem;

  assign w_mem_hold = bus.mem_req & ~bus.mem_ready;
  assign w_load_use = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));

  always_comb begin
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_stall_mem  = 1'b0;
    w_flush_id   = 1'b0;
    w_bubble_ex  = 1'b0;
    w_bubble_mem = 1'b0;
    if (w_mem_hold) begin
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_stall_ex  = 1'b1;
      w_stall_mem = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_mdu_start) begin
            // An op whose result is already back completes without stalling.
            w_stall_if   = ~bus.mdu_done;
            w_stall_id   = ~bus.mdu_done;
            w_stall_ex   = ~bus.mdu_done;
            w_bubble_mem = ~bus.mdu_done;
          end else if (bus.ex_redirect) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
          end else if (w_load_use) begin
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_bubble_ex = 1'b1;
          end
        end
        ST_MDU_BUSY: begin
          w_stall_if   = ~bus.mdu_done;
          w_stall_id   = ~bus.mdu_done;
          w_stall_ex   = ~bus.mdu_done;
          w_bubble_mem = ~bus.mdu_done;
        end
        default: ; // drain with memory ready: result already held, release
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!w_mem_hold && bus.ex_mdu_start && !bus.mdu_done) r_state <= ST_MDU_BUSY;
        end
        ST_MDU_BUSY: begin
          if (bus.mdu_done) r_state <= w_mem_hold ? ST_MDU_DRAIN : ST_RUN;
        end
        ST_MDU_DRAIN: begin
          if (!w_mem_hold) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_mem_hold) begin
        if (r_wait_cnt != c_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt >= c_timeout_m1) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_stall_if && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign bus.stall_if     = w_stall_if;
  assign bus.stall_id     = w_stall_id;
  assign bus.stall_ex     = w_stall_ex;
  assign bus.stall_mem    = w_stall_mem;
  assign bus.flush_id     = w_flush_id;
  assign bus.bubble_ex    = w_bubble_ex;
  assign bus.bubble_mem   = w_bubble_mem;
  assign bus.seq_state    = r_state;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-cycle performance counter.
REQ-002 Parameter MEM_TIMEOUT, default 255, consecutive memory-wait cycles before the timeout flag sets.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_rd_addr  input  5  destination of the instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 ex_redirect  input  1  branch/jump resolved taken in EX.
REQ-010 ex_mdu_start  input  1  multiply/divide op in EX issuing to the MDU.
REQ-011 mdu_done  input  1  MDU result valid, single-cycle pulse.
REQ-012 mem_req, mem_ready  input  1 each  data-memory request in MEM and its ready.
REQ-013 stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
REQ-014 flush_id  output  1  clear IF/ID to NOP.
REQ-015 bubble_ex, bubble_mem  output  1 each  load NOP into ID/EX, EX/MEM.
REQ-016 seq_state  output  2  FSM state: 0 RUN, 1 MDU_BUSY, 2 MDU_DRAIN.
REQ-017 mem_timeout  output  1  sticky memory-wait timeout flag.
REQ-018 stall_cycles  output  CNT_W  count of cycles with stall_if high.

Function
REQ-019 mem_hold = mem_req AND NOT mem_ready, combinational, in every state.
REQ-020 mem_hold SHALL assert all four stalls, deassert flush_id, bubble_ex, bubble_mem; highest priority.
REQ-021 load_use = ex_mem_read, ex_rd_addr != 0, and (id_uses_rs1 with rs1 == rd, or id_uses_rs2 with rs2 == rd).
REQ-022 RUN, no mem_hold, ex_mdu_start: stall_if/id/ex and bubble_mem asserted same cycle; next state MDU_BUSY unless mdu_done also high (then stay RUN, no stall).
REQ-023 RUN, no mem_hold, no mdu start, ex_redirect: flush_id and bubble_ex, no stalls; load_use ignored.
REQ-024 RUN, none of the above, load_use: stall_if, stall_id, bubble_ex for exactly that cycle.
REQ-025 MDU_BUSY: stall_if/id/ex and bubble_mem held (mem_hold overrides per REQ-020); ex_redirect, load_use ignored.
REQ-026 MDU_BUSY, mdu_done, no mem_hold: stalls released that cycle, next RUN.
REQ-027 MDU_BUSY, mdu_done with mem_hold: next MDU_DRAIN (done remembered).
REQ-028 MDU_DRAIN: stalls as MDU_BUSY; first cycle without mem_hold releases stalls, next RUN; further mdu_done ignored.
REQ-029 A redirect held in EX during a stall SHALL act in the first non-stalled RUN cycle.
REQ-030 Wait counter increments on mem_hold, clears otherwise, saturates at MEM_TIMEOUT; reaching MEM_TIMEOUT sets mem_timeout until reset.
REQ-031 stall_cycles increments each cycle stall_if is 1; saturates at all-ones.
REQ-032 Stall, flush, bubble outputs are combinational from state and inputs; seq_state, mem_timeout, stall_cycles are registered.

Reset
REQ-033 rst_n low SHALL immediately force state RUN, wait counter 0, mem_timeout 0, stall_cycles 0, regardless of clk.
REQ-034 Reset mid-MDU_BUSY/MDU_DRAIN abandons the pending op; first cycle after release is RUN.
REQ-035 Under reset all stall/flush/bubble outputs follow RUN rules from current inputs.

Verification
REQ-036 Load x5 in EX, ID reads x5 via rs2 -> one cycle stall_if/stall_id/bubble_ex; rd = x0 -> no stall.
REQ-037 ex_mdu_start, mdu_done 4 cycles later -> stalls for 4 cycles, seq_state 1 then 0, stall_cycles = 4.
REQ-038 MDU_BUSY, mdu_done while mem_hold for 3 more cycles -> seq_state 2, all stalls, release on first ready cycle.
REQ-039 ex_redirect with concurrent load_use -> flush_id, bubble_ex, no stall_if.
REQ-040 MEM_TIMEOUT=4, mem_req with mem_ready low 4 cycles -> mem_timeout set on 4th edge, stays set after ready.
REQ-041 rst_n low during MDU_BUSY -> seq_state 0, counters 0 asynchronously.
